apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
APB master sequencer that sits directly upstream of the APB slave in the AHB-to-APB path. It accepts one transfer at a time from the AHB-side request logic over a valid/ready interface and drives the APB SETUP and ACCESS phases. It waits for PREADY, guarded by a timeout, then returns read data and the 2-bit error code over a one-deep valid/ready response interface.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and request/response data
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles without PREADY before the master aborts; 0 disables the timeout
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived, not overridden)

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  transfer request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  32  transfer address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response holding register full
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  2  00 ok, 01 write error, 10 read error, 11 timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  32  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB transfer complete
PSLVERR  in  2  slave error code

Behaviour:
- Clock and reset: PCLK is the clock; PRESETn is the reset, asynchronous, active-low.
- Reset values: all outputs are 0, state = IDLE, wait counter = 0, and rsp_valid = 0 immediately on reset assertion.
- All APB outputs and response outputs are registered. There is no combinational path from PREADY to any output. req_ready is combinational from state and rsp_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = !rsp_valid || rsp_ready.
  - On a handshake, latch PWRITE/PADDR/PWDATA from req_* and go to SETUP.
  - PSEL = 0, PENABLE = 0.
- SETUP (exactly one cycle): PSEL = 1, PENABLE = 0, then go to ACCESS unconditionally.
- ACCESS:
  - PSEL = 1, PENABLE = 1; PADDR/PWRITE/PWDATA are held stable.
  - The wait counter increments each cycle in which PREADY is sampled 0.
  - PREADY sampled 1: load rsp_rdata = PWRITE ? 0 : PRDATA; load rsp_err = PSLVERR; set rsp_valid = 1; drop PSEL/PENABLE next cycle; go to IDLE.
  - Counter reaches TIMEOUT_CYCLES with PREADY = 0 (TIMEOUT_CYCLES > 0 only): load rsp_err = 11, rsp_rdata = 0, set rsp_valid = 1, go to IDLE.
- Latency with a slave that returns PREADY in the 2nd ACCESS cycle:
  - handshake at edge T
  - SETUP in cycle T+1
  - ACCESS in cycles T+2 and T+3
  - rsp_valid high from T+4
- Back-to-back transfers: a new request can be accepted in the same IDLE cycle that the previous response is consumed, provided rsp_ready = 1. Minimum gap is one IDLE cycle with PSEL = 0 between transfers; no PSEL-held chaining.
- Response register: rsp_valid clears on rsp_valid && rsp_ready unless it is reloaded in the same cycle. A reload cannot occur in that cycle, because ACCESS completion only occurs outside IDLE.
- Simultaneous events: PREADY = 1 on the same cycle the counter hits its limit counts as success; PREADY has priority.
- Reset mid-transfer: the transfer is abandoned, PSEL/PENABLE fall asynchronously, and no response is produced.
- req_* is ignored outside the IDLE handshake. A change of req_* during SETUP or ACCESS has no effect on the APB outputs.

Decomposition:
- Package apb_pkg:
  - state encoding: IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2
  - error codes: ERR_OK = 2'b00, ERR_WR = 2'b01, ERR_RD = 2'b10, ERR_TIMEOUT = 2'b11
- One sub-module, apb_wait_timer: a clearable counter with an expired flag, parameterised by TIMEOUT_CYCLES, cleared on entry to ACCESS.

Test Plan:
1. Write req_addr=0x40000010, wdata=0xDEADBEEF; slave gives PREADY in the 2nd ACCESS cycle with PSLVERR=00 -> PADDR/PWDATA stable through SETUP+ACCESS; rsp_valid at T+4; rsp_err=00; rsp_rdata=0.
2. Read 0x40000010 after test 1; slave returns PRDATA=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_err=00.
3. Write to 0x50000004; slave returns PSLVERR=01 -> rsp_err=01; then a read of the same address with PSLVERR=10 -> rsp_err=10, rsp_rdata=PRDATA as sampled.
4. Hold PREADY=0 with TIMEOUT_CYCLES=16 -> PSEL drops after 16 ACCESS cycles; rsp_err=11; rsp_rdata=0; the next request is accepted normally.
5. Hold rsp_ready=0 after one response while req_valid=1 -> req_ready=0 and PSEL stays 0; raise rsp_ready -> request accepted in that same cycle; SETUP follows.
6. Drop PRESETn in the ACCESS cycle -> PSEL/PENABLE/rsp_valid go 0 asynchronously; after release, the FSM is in IDLE and req_ready=1.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
// Shared encodings for the APB master sequencer.
// Holds the FSM state type, the response error codes and the wait-counter width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_WR      = 2'b01;
    localparam logic [1:0] ERR_RD      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // A disabled timeout (0) still needs a one-bit counter so the timer elaborates.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundle of the request, response and APB bus signals around the master sequencer.
// The master modport is the sequencer's view; slave is the view of everything around it.
interface apb_master_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic [1:0]            PSLVERR;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err,
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err,
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );

endinterface

// File: rtl/apb_master_ctrl_wait_timer.sv
// Counts ACCESS-phase cycles spent waiting for PREADY and flags the last permitted cycle.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES) : '1;

    logic [CNT_WIDTH-1:0] count_q;

    // Saturates at the limit so a disabled timeout never wraps back around.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // High while the current wait cycle is the one whose increment reaches the limit.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign expired = (count_q == CNT_LIMIT - 1'b1);
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: takes one request at a time, runs SETUP/ACCESS on the APB bus
// and returns read data plus a 2-bit error code through a one-deep response register.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_master_ctrl_if.master  bus
);

    apb_state_t state_q;
    apb_state_t state_d;

    logic                  req_ready;
    logic                  handshake;
    logic                  access_done;
    logic                  access_timeout;
    logic                  tmr_clear;
    logic                  tmr_inc;
    logic                  tmr_expired;

    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_err_q;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PREADY is checked before the timeout so a last-cycle completion still counts as success.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        handshake      = 1'b0;
        access_done    = 1'b0;
        access_timeout = 1'b0;
        tmr_clear      = 1'b0;
        tmr_inc        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rsp_valid_q || bus.rsp_ready;
                if (bus.req_valid && req_ready) begin
                    handshake = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                tmr_clear = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    access_done = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expired) begin
                        access_timeout = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // APB strobes follow the next state so they come straight out of flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            if (handshake) begin
                pwrite_q <= bus.req_write;
                paddr_q  <= bus.req_addr;
                pwdata_q <= bus.req_wdata;
            end
        end
    end

    // Completion only happens outside IDLE, so load and consume never coincide.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else if (access_done) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q   <= bus.PSLVERR;
        end else if (access_timeout) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_TIMEOUT;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus randomized transfers
// checked against a transaction-level model of latency, timeout and response contents.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int TIMEOUT = 16;

    logic PCLK;
    logic PRESETn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    apb_master_ctrl_if #(.DATA_WIDTH(32)) bus ();

    apb_master_ctrl #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Model: ACCESS lasts until PREADY or until TIMEOUT wait cycles, plus SETUP and the response cycle.
    function automatic int exp_access(input int ready_after);
        return (ready_after < TIMEOUT) ? ready_after + 1 : TIMEOUT;
    endfunction

    function automatic logic [1:0] exp_err(input int ready_after, input logic [1:0] slverr);
        return (ready_after < TIMEOUT) ? slverr : ERR_TIMEOUT;
    endfunction

    function automatic logic [31:0] exp_rdata(input int ready_after, input logic wr, input logic [31:0] prdata);
        return (ready_after < TIMEOUT && !wr) ? prdata : 32'h0;
    endfunction

    // Drives one transfer and plays the slave: PREADY is raised in ACCESS cycle number ready_after (0-based).
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_after, input logic [31:0] prdata, input logic [1:0] slverr,
                            output logic [31:0] o_rdata, output logic [1:0] o_err, output int o_setup,
                            output int o_access, output int o_lat, output bit o_stable, output bit o_ok);
        int idx;
        o_rdata = '0; o_err = '0; o_setup = 0; o_access = 0; o_lat = 0; o_stable = 1'b1; o_ok = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
        #1;
        for (int w = 0; w < 20 && bus.req_ready !== 1'b1; w++) begin
            @(posedge PCLK); #2;
        end
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge PCLK); #2;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_write = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        for (int n = 1; n <= 100; n++) begin
            if (bus.rsp_valid === 1'b1) begin
                o_lat = n; o_rdata = bus.rsp_rdata; o_err = bus.rsp_err;
                o_ok = (bus.PSEL === 1'b0) && (bus.PENABLE === 1'b0);
                break;
            end
            bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 2'($urandom);
            if (bus.PSEL === 1'b1) begin
                if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata) o_stable = 1'b0;
                if (bus.PENABLE === 1'b0) begin
                    o_setup++;
                    bus.PREADY = 1'($urandom);
                end else begin
                    idx = o_access;
                    o_access++;
                    if (idx == ready_after) begin
                        bus.PREADY = 1'b1; bus.PRDATA = prdata; bus.PSLVERR = slverr;
                    end
                end
            end
            @(posedge PCLK); #2;
        end
        bus.PREADY = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #2;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_strobes: got %b required 000", {bus.PSEL, bus.PENABLE, bus.PWRITE});
        end
        n_cmp++;
        if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_addr_data: got %h/%h required 0/0", bus.PADDR, bus.PWDATA);
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 35'h0) begin
            n_fail++; $display("[TB] FAIL reset_rsp: got v=%b e=%b d=%h required all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #2;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.PSEL !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_release_idle: got ready=%b psel=%b required 1/0", bus.req_ready, bus.PSEL);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        run_xfer(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 1, $urandom, 2'b00, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || !st) begin
            n_fail++; $display("[TB] FAIL write_completion_stable: got ok=%0d stable=%0d required 1/1", ok, st);
        end
        n_cmp++;
        if (lat != 4 || su != 1 || ac != 2) begin
            n_fail++; $display("[TB] FAIL write_latency: got lat=%0d setup=%0d access=%0d required 4/1/2", lat, su, ac);
        end
        n_cmp++;
        if (er !== ERR_OK || rd !== 32'h0) begin
            n_fail++; $display("[TB] FAIL write_rsp: got err=%b data=%h required 00/0", er, rd);
        end
        repeat (2) @(posedge PCLK);
        #2;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rsp_hold: got valid=%b required 1", bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        @(posedge PCLK); #2;
        bus.rsp_ready = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rsp_consume: got valid=%b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        run_xfer(1'b0, 32'h4000_0010, $urandom, 1, 32'hDEAD_BEEF, 2'b00, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || !st || lat != 4) begin
            n_fail++; $display("[TB] FAIL read_timing: got ok=%0d stable=%0d lat=%0d required 1/1/4", ok, st, lat);
        end
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== ERR_OK) begin
            n_fail++; $display("[TB] FAIL read_rsp: got data=%h err=%b required deadbeef/00", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        run_xfer(1'b1, 32'h5000_0004, 32'hA5A5_0001, $urandom_range(0, 3), $urandom, ERR_WR, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || er !== ERR_WR || rd !== 32'h0) begin
            n_fail++; $display("[TB] FAIL write_err: got ok=%0d err=%b data=%h required 1/01/0", ok, er, rd);
        end
        run_xfer(1'b0, 32'h5000_0004, $urandom, 2, 32'h1234_5678, ERR_RD, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || er !== ERR_RD || rd !== 32'h1234_5678 || lat != 5) begin
            n_fail++; $display("[TB] FAIL read_err: got ok=%0d err=%b data=%h lat=%0d required 1/10/12345678/5", ok, er, rd, lat);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        run_xfer(1'b0, 32'h6000_0000, $urandom, TIMEOUT + 4, $urandom, 2'b00, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || ac != TIMEOUT || lat != TIMEOUT + 2) begin
            n_fail++; $display("[TB] FAIL timeout_len: got ok=%0d access=%0d lat=%0d required 1/%0d/%0d", ok, ac, lat, TIMEOUT, TIMEOUT + 2);
        end
        n_cmp++;
        if (er !== ERR_TIMEOUT || rd !== 32'h0) begin
            n_fail++; $display("[TB] FAIL timeout_rsp: got err=%b data=%h required 11/0", er, rd);
        end
        run_xfer(1'b0, 32'h6000_0004, $urandom, TIMEOUT - 1, 32'hCAFE_F00D, ERR_RD, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || ac != TIMEOUT || er !== ERR_RD || rd !== 32'hCAFE_F00D) begin
            n_fail++; $display("[TB] FAIL pready_priority: got ok=%0d access=%0d err=%b data=%h required 1/%0d/10/cafef00d", ok, ac, er, rd, TIMEOUT);
        end
        run_xfer(1'b1, 32'h6000_0008, $urandom, 0, $urandom, 2'b00, rd, er, su, ac, lat, st, ok);
        n_cmp++;
        if (!ok || lat != 3 || er !== ERR_OK) begin
            n_fail++; $display("[TB] FAIL after_timeout: got ok=%0d lat=%0d err=%b required 1/3/00", ok, lat, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        run_xfer(1'b0, 32'h7000_0000, $urandom, 0, 32'h0BAD_CAFE, 2'b00, rd, er, su, ac, lat, st, ok);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h7000_0040; bus.req_wdata = 32'h1111_2222;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b0 || bus.PSEL !== 1'b0 || bus.rsp_valid !== 1'b1) begin
                n_fail++; $display("[TB] FAIL b2b_blocked: got ready=%b psel=%b valid=%b required 0/0/1", bus.req_ready, bus.PSEL, bus.rsp_valid);
            end
            @(posedge PCLK); #3;
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_same_cycle_ready: got %b required 1", bus.req_ready);
        end
        @(posedge PCLK); #2;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h0;
        n_cmp++;
        if ({bus.rsp_valid, bus.PSEL, bus.PENABLE} !== 3'b010 || bus.PADDR !== 32'h7000_0040) begin
            n_fail++; $display("[TB] FAIL b2b_setup: got v/sel/en=%b addr=%h required 010/70000040", {bus.rsp_valid, bus.PSEL, bus.PENABLE}, bus.PADDR);
        end
        @(posedge PCLK); #2;
        n_cmp++;
        if (bus.PENABLE !== 1'b1 || bus.PADDR !== 32'h7000_0040 || bus.PWDATA !== 32'h1111_2222) begin
            n_fail++; $display("[TB] FAIL b2b_access: got en=%b addr=%h wdata=%h required 1/70000040/11112222", bus.PENABLE, bus.PADDR, bus.PWDATA);
        end
        bus.PREADY = 1'b1; bus.PSLVERR = ERR_WR; bus.PRDATA = 32'h9999_9999;
        @(posedge PCLK); #2;
        bus.PREADY = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== ERR_WR || bus.rsp_rdata !== 32'h0 || bus.PSEL !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_rsp: got v=%b err=%b data=%h psel=%b required 1/01/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, prdata; logic [1:0] er, slverr; logic wr;
        int su, ac, lat, ra, pick; bit st, ok;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom); addr = $urandom; wdata = $urandom; prdata = $urandom; slverr = 2'($urandom);
            pick = $urandom_range(0, 7);
            ra = (pick < 5) ? pick : (pick == 5) ? TIMEOUT - 1 : (pick == 6) ? TIMEOUT : TIMEOUT + 7;
            run_xfer(wr, addr, wdata, ra, prdata, slverr, rd, er, su, ac, lat, st, ok);
            n_cmp++;
            if (!ok || !st) begin
                n_fail++; $display("[TB] FAIL rand_%0d_completion: got ok=%0d stable=%0d required 1/1", i, ok, st);
            end
            n_cmp++;
            if (su != 1 || ac != exp_access(ra) || lat != exp_access(ra) + 2) begin
                n_fail++; $display("[TB] FAIL rand_%0d_timing: got setup=%0d access=%0d lat=%0d required 1/%0d/%0d", i, su, ac, lat, exp_access(ra), exp_access(ra) + 2);
            end
            n_cmp++;
            if (rd !== exp_rdata(ra, wr, prdata) || er !== exp_err(ra, slverr)) begin
                n_fail++; $display("[TB] FAIL rand_%0d_rsp: got data=%h err=%b required %h/%b", i, rd, er, exp_rdata(ra, wr, prdata), exp_err(ra, slverr));
            end
            if ($urandom_range(0, 1) == 1) begin
                bus.rsp_ready = 1'b1;
                @(posedge PCLK); #2;
                bus.rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] er; int su, ac, lat; bit st, ok;
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h8000_0000;
        @(posedge PCLK); #2;
        bus.req_valid = 1'b0;
        @(posedge PCLK); #2;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL midreset_in_access: got %b required 11", {bus.PSEL, bus.PENABLE});
        end
        bus.PREADY = 1'b1; bus.PRDATA = 32'h5555_AAAA;
        #1 PRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL midreset_async: got sel/en/v=%b required 000", {bus.PSEL, bus.PENABLE, bus.rsp_valid});
        end
        @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge PCLK);
        #2;
        bus.PREADY = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midreset_release: got v=%b psel=%b ready=%b required 0/0/1", bus.rsp_valid, bus.PSEL, bus.req_ready);
        end
        run_xfer(1'b0, 32'h8000_0004, $urandom, 0, 32'h7777_0000, 2'b00, rd, er, su, ac, lat, st, ok);
        #1 PRESETn = 1'b0;
        #1;
        n_cmp++;
        if (!ok || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_clears_rsp: got ok=%0d valid=%b required 1/0", ok, bus.rsp_valid);
        end
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #2;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = '0;
        PRESETn = 1'b1;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
